// File: rtl/aes_wb_queue.sv
// aes_wb_queue
// Wishbone slave that queues AES-128 plaintext blocks for an external encrypt
// core and queues the ciphertext results so software can stream blocks in and
// drain results out without sequencing every block by hand.
//
// Ports:
//   wb_clk_i / wb_rst_i            clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i     Wishbone request (sel ignored, full words)
//   wbs_adr_i/dat_i                address (only [11:2] decoded), write data
//   wbs_ack_o/dat_o                registered acknowledge and read data
//   core_nrst/core_in/core_key     run control, plaintext and key to the core
//   core_out/core_rdy              ciphertext and its valid flag from the core
//   irq                            only when AES_QUEUE_IRQ_EN is defined
//
// Optional feature macro: AES_QUEUE_IRQ_EN adds a registered irq output
// (mask & (output not empty | timeout)) controlled by CTRL bit 2.
module aes_wb_queue #(
    parameter int DEPTH        = 4,
    parameter int CORE_TIMEOUT = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic         core_nrst,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_rdy
`ifdef AES_QUEUE_IRQ_EN
    ,
    output logic         irq
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
    localparam logic [7:0]  TIMEOUT_CNT = 8'(CORE_TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, STORE} engineState_e;

    engineState_e r_state, w_nextState;

    logic          r_ack;
    logic [31:0]   r_rdData;
    logic [31:0]   r_key   [4];
    logic [31:0]   r_stage [4];
    logic [127:0]  r_inMem  [DEPTH];
    logic [127:0]  r_outMem [DEPTH];
    logic [AW-1:0] r_inWr, r_inRd, r_outWr, r_outRd;
    logic [AW:0]   r_inCount, r_outCount;
    logic          r_enable, r_inOverflow, r_outUnderflow, r_keyErr, r_timeout;
    logic [7:0]    r_timer;
    logic [127:0]  r_coreIn;

    logic          w_req, w_wr, w_rd;
    logic [9:0]    w_word;
    logic          w_inFull, w_inEmpty, w_outFull, w_outEmpty, w_busy;
    logic          w_flush, w_busPush, w_inPush, w_inPop, w_outPop, w_outPush;
    logic          w_storeOk, w_timeoutHit;
    logic [127:0]  w_pushData, w_outHead;
    logic [31:0]   w_status, w_rdMux;
    logic [3:0]    w_inCnt4, w_outCnt4;
    logic          w_unused;

    // A new request is only taken when ack is low, so ack never repeats.
    assign w_req  = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr   = w_req & wbs_we_i;
    assign w_rd   = w_req & ~wbs_we_i;
    assign w_word = wbs_adr_i[11:2];

    assign w_inFull   = (r_inCount == FULL_CNT);
    assign w_inEmpty  = (r_inCount == '0);
    assign w_outFull  = (r_outCount == FULL_CNT);
    assign w_outEmpty = (r_outCount == '0);
    assign w_busy     = (r_state != IDLE);

    // Writing 0x02C completes the staging block, so its own data is word 3.
    assign w_flush    = w_wr && (w_word == 10'd1) && wbs_dat_i[1];
    assign w_busPush  = w_wr && (w_word == 10'd11);
    assign w_inPush   = w_busPush && !w_inFull;
    assign w_inPop    = (r_state == LOAD);
    assign w_pushData = {wbs_dat_i, r_stage[2], r_stage[1], r_stage[0]};
    assign w_outPop   = w_rd && (w_word == 10'd15) && !w_outEmpty;
    // A full output queue being popped this cycle still has room for the result.
    assign w_storeOk  = (r_state == STORE) && (!w_outFull || w_outPop);
    assign w_outPush  = w_storeOk && !w_flush;
    assign w_timeoutHit = (r_state == RUN) && !core_rdy && (r_timer == TIMEOUT_CNT);
    assign w_outHead  = r_outMem[r_outRd];

    assign w_inCnt4  = 4'(r_inCount);
    assign w_outCnt4 = 4'(r_outCount);
    assign w_status  = {12'b0, w_outCnt4, w_inCnt4, 2'b0, r_timeout, r_keyErr,
                        r_outUnderflow, r_inOverflow, r_enable, w_outEmpty,
                        w_outFull, w_inEmpty, w_inFull, w_busy};

    assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[31:12], wbs_adr_i[1:0]};

    // Read data mux; write-only and unmapped words return the marker pattern.
    always_comb begin
        w_rdMux = 32'hDEADB00F;
        if (w_word == 10'd0) begin
            w_rdMux = w_status;
        end else if (w_word[9:2] == 8'd1) begin
            w_rdMux = r_key[w_word[1:0]];
        end else if (w_word[9:2] == 8'd2) begin
            w_rdMux = r_stage[w_word[1:0]];
        end else if (w_word[9:2] == 8'd3) begin
            w_rdMux = w_outEmpty ? 32'h0 : w_outHead[{w_word[1:0], 5'b0} +: 32];
        end
    end

    // Bus-facing registers: ack, read data, control, key, staging, sticky flags.
    // Sticky sets are written after clears so a same-cycle event is not lost.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack          <= 1'b0;
            r_rdData       <= '0;
            r_enable       <= 1'b0;
            r_inOverflow   <= 1'b0;
            r_outUnderflow <= 1'b0;
            r_keyErr       <= 1'b0;
            r_timeout      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_key[i]   <= '0;
                r_stage[i] <= '0;
            end
        end else begin
            r_ack    <= w_req;
            r_rdData <= w_rd ? w_rdMux : 32'h0;
            if (w_wr) begin
                if (w_word == 10'd1) begin
                    r_enable <= wbs_dat_i[0];
                end else if (w_word == 10'd2) begin
                    if (wbs_dat_i[6]) r_inOverflow   <= 1'b0;
                    if (wbs_dat_i[7]) r_outUnderflow <= 1'b0;
                    if (wbs_dat_i[8]) r_keyErr       <= 1'b0;
                    if (wbs_dat_i[9]) r_timeout      <= 1'b0;
                end else if (w_word[9:2] == 8'd1) begin
                    if (w_busy) r_keyErr <= 1'b1;
                    else        r_key[w_word[1:0]] <= wbs_dat_i;
                end else if (w_word[9:2] == 8'd2) begin
                    r_stage[w_word[1:0]] <= wbs_dat_i;
                end
            end
            if (w_busPush && w_inFull) r_inOverflow <= 1'b1;
            if (w_rd && (w_word == 10'd15) && w_outEmpty) r_outUnderflow <= 1'b1;
            if (w_timeoutHit) r_timeout <= 1'b1;
        end
    end

    // FIFO storage needs no reset; validity is tracked by pointers and counts.
    always_ff @(posedge wb_clk_i) begin
        if (w_inPush)  r_inMem[r_inWr]   <= w_pushData;
        if (w_outPush) r_outMem[r_outWr] <= core_out;
    end

    // FIFO pointers and counts; flush wins over any same-cycle push or pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_inWr <= '0; r_inRd <= '0; r_inCount <= '0;
            r_outWr <= '0; r_outRd <= '0; r_outCount <= '0;
        end else if (w_flush) begin
            r_inWr <= '0; r_inRd <= '0; r_inCount <= '0;
            r_outWr <= '0; r_outRd <= '0; r_outCount <= '0;
        end else begin
            if (w_inPush)  r_inWr  <= r_inWr + 1'b1;
            if (w_inPop)   r_inRd  <= r_inRd + 1'b1;
            if (w_inPush && !w_inPop)      r_inCount <= r_inCount + 1'b1;
            else if (!w_inPush && w_inPop) r_inCount <= r_inCount - 1'b1;
            if (w_outPush) r_outWr <= r_outWr + 1'b1;
            if (w_outPop)  r_outRd <= r_outRd + 1'b1;
            if (w_outPush && !w_outPop)      r_outCount <= r_outCount + 1'b1;
            else if (!w_outPush && w_outPop) r_outCount <= r_outCount - 1'b1;
        end
    end

    // Engine state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // Engine next state. Clearing enable only blocks new dispatches, so a
    // block already in flight runs to completion.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:  if (r_enable && !w_inEmpty) w_nextState = LOAD;
            LOAD:  w_nextState = RUN;
            RUN: begin
                if (core_rdy)                      w_nextState = STORE;
                else if (r_timer == TIMEOUT_CNT)   w_nextState = IDLE;
            end
            STORE: if (w_storeOk) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (w_flush) w_nextState = IDLE;
    end

    // Core-side datapath: latch the head block on dispatch, time the run.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_coreIn <= '0;
            r_timer  <= '0;
        end else begin
            if (w_inPop) r_coreIn <= r_inMem[r_inRd];
            if (r_state == LOAD)     r_timer <= '0;
            else if (r_state == RUN) r_timer <= r_timer + 1'b1;
        end
    end

`ifdef AES_QUEUE_IRQ_EN
    logic r_irqMask, r_irq;

    // Interrupt mask lives in CTRL bit 2; irq is registered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irqMask <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && (w_word == 10'd1)) r_irqMask <= wbs_dat_i[2];
            r_irq <= r_irqMask & (!w_outEmpty | r_timeout);
        end
    end

    assign irq = r_irq;
`endif

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdData;
    assign core_nrst = (r_state == RUN) || (r_state == STORE);
    assign core_in   = r_coreIn;
    assign core_key  = {r_key[3], r_key[2], r_key[1], r_key[0]};

endmodule
